// File: rtl/conv_s2_fmap_collector.sv
// Collects stride-2 conv results, tags row/col/end-of-frame, buffers them and hands them downstream via valid/ready.
// Head word appears one cycle after its write into an empty FIFO; m_ready stalls the head, and words arriving while full are dropped.
// Optional macro COLLECTOR_RELU_EN zeroes negative words before they are stored.
module conv_s2_fmap_collector #(
    parameter int IMG_WIDHT  = 299,
    parameter int IMG_HEIGHT = 299,
    parameter int DATA_WIDHT = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDHT-1:0]         Data_In,
    input  logic                          Valid_In,
    output logic [DATA_WIDHT-1:0]         m_data,
    output logic                          m_last_col,
    output logic                          m_last_frame,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          frame_done,
    output logic                          overflow,
    input  logic                          clear,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);
    localparam int OUT_W = (IMG_WIDHT - 3) / 2 + 1;
    localparam int OUT_H = (IMG_HEIGHT - 3) / 2 + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(OUT_W + 1);
    localparam int RW    = $clog2(OUT_H + 1);
    localparam int EW    = DATA_WIDHT + 2;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

    // Entry layout: {last_frame, last_col, data}
    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    state_t                r_state;
    logic [DATA_WIDHT-1:0] r_m_data;
    logic                  r_m_last_col;
    logic                  r_m_last_frame;
    logic                  r_m_valid;
    logic                  r_frame_done;
    logic                  r_overflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_last_col;
    logic                  w_last_row;
    logic [DATA_WIDHT-1:0] w_wdata;
    logic [EW-1:0]         w_wentry;
    logic [AW:0]           w_wr_ptr_nxt;
    logic [AW:0]           w_rd_ptr_nxt;
    logic [EW-1:0]         w_head_nxt;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = r_m_valid && m_ready;
    assign w_push     = Valid_In && (r_state == S_IDLE || r_state == S_COLLECT) && (!w_full || w_pop);
    assign w_drop     = Valid_In && !w_push;
    assign w_last_col = (r_col == CW'(OUT_W - 1));
    assign w_last_row = (r_row == RW'(OUT_H - 1));

`ifdef COLLECTOR_RELU_EN
    assign w_wdata = Data_In[DATA_WIDHT-1] ? '0 : Data_In;
`else
    assign w_wdata = Data_In;
`endif

    assign w_wentry     = {w_last_col && w_last_row, w_last_col, w_wdata};
    assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);

    // Slot collision with the write only happens when the FIFO drains to empty this cycle, so bypass the new word.
    always_comb begin
        w_head_nxt = '0;
        if (w_wr_ptr_nxt != w_rd_ptr_nxt) begin
            if (w_push && (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0]))
                w_head_nxt = w_wentry;
            else
                w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= w_wentry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_col          <= '0;
            r_row          <= '0;
            r_state        <= S_IDLE;
            r_m_data       <= '0;
            r_m_last_col   <= 1'b0;
            r_m_last_frame <= 1'b0;
            r_m_valid      <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overflow     <= 1'b0;
        end else if (clear) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_col          <= '0;
            r_row          <= '0;
            r_state        <= S_IDLE;
            r_m_data       <= '0;
            r_m_last_col   <= 1'b0;
            r_m_last_frame <= 1'b0;
            r_m_valid      <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_m_valid      <= (w_wr_ptr_nxt != w_rd_ptr_nxt);
            r_m_data       <= w_head_nxt[DATA_WIDHT-1:0];
            r_m_last_col   <= w_head_nxt[DATA_WIDHT];
            r_m_last_frame <= w_head_nxt[DATA_WIDHT+1];
            r_frame_done   <= 1'b0;
            if (w_drop)
                r_overflow <= 1'b1;
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (w_push) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= w_last_row ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        r_state <= (w_last_col && w_last_row) ? S_DRAIN : S_COLLECT;
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_col   <= '0;
                    r_row   <= '0;
                end
            endcase
        end
    end

    assign m_data       = r_m_data;
    assign m_last_col   = r_m_last_col;
    assign m_last_frame = r_m_last_frame;
    assign m_valid      = r_m_valid;
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;
    assign fill_level   = r_wr_ptr - r_rd_ptr;
endmodule

// File: doc/conv_s2_fmap_collector.md
Name: conv_s2_fmap_collector

Overview:
- Sink-side companion of the 3x3 stride-2 convolution engine.
- Accepts that engine's Data_Out/Valid_Out stream, which is a push-only interface with no back-pressure.
- Tags each result with its output row/column and end-of-row/end-of-frame markers.
- Buffers results in a FIFO and hands them downstream over a valid/ready handshake; frame completion, drops and occupancy are reported.

Parameters:
IMG_WIDHT, 299, input image width in pixels; output width OUT_W = (IMG_WIDHT-3)/2+1
IMG_HEIGHT, 299, input image height; output height OUT_H = (IMG_HEIGHT-3)/2+1
DATA_WIDHT, 32, result word width (two's complement)
FIFO_DEPTH, 16, buffer entries, power of two, >= 4

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
Data_In  in  DATA_WIDHT  result word from convolution engine
Valid_In  in  1  Data_In valid this cycle; cannot be stalled
m_data  out  DATA_WIDHT  FIFO head word
m_last_col  out  1  head is last column of its row
m_last_frame  out  1  head is last word of the frame
m_valid  out  1  head present
m_ready  in  1  downstream accepts head
frame_done  out  1  one-cycle pulse, frame fully drained
overflow  out  1  sticky: an input word was dropped
clear  in  1  synchronous: clears overflow and counters, forces IDLE
fill_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, async) and clear=1 (sync) both give the same state:
  - FSM in IDLE; FIFO empty; col=row=0.
  - m_valid=0, frame_done=0, overflow=0, fill_level=0; m_data and tags are 0.
- Reset mid-frame discards all buffered words; no frame_done is issued.
- FSM states:
  - IDLE: a Valid_In word is written as the first pixel; go to COLLECT.
  - COLLECT: each Valid_In word is written with the current col/row tags.
    - col increments and wraps to 0 at OUT_W-1; row then increments.
    - Writing row=OUT_H-1, col=OUT_W-1 sets m_last_frame on that entry; go to DRAIN.
  - DRAIN: Valid_In words are dropped and set overflow. Stay until the FIFO is empty.
  - DONE: one cycle; frame_done=1; col=row=0; return to IDLE. A Valid_In in DONE is dropped and sets overflow.
- Tagging: m_last_col=1 when the entry was written with col=OUT_W-1.
- FIFO:
  - Write when Valid_In and the FSM is in IDLE/COLLECT and (not full, or a pop occurs the same cycle).
  - Pop when m_valid && m_ready.
- Full and Valid_In with no pop: the word is dropped, overflow=1 (sticky until clear/reset), and counters do not advance.
- Simultaneous push and pop: fill_level unchanged; correct ordering is kept even at full or at one entry.
- Latency:
  - A word written into an empty FIFO appears on m_valid the next cycle.
  - m_data, the tags and m_valid are registered.
  - m_data and the tags are stable while m_valid && !m_ready.
- m_valid is never dropped without a pop.
- Data is passed bit-exact; no arithmetic except the optional ReLU.
- Read/write pointers wrap modulo FIFO_DEPTH; a pointer-extension bit distinguishes full from empty.

Optional Feature:
- Macro COLLECTOR_RELU_EN.
- When defined: each word is stored as 0 if Data_In[DATA_WIDHT-1]=1, otherwise unchanged. The ReLU is applied combinationally before the FIFO write, so latency is unchanged.
- When undefined: words are stored unmodified; no ReLU logic is generated.

Test Plan:
- IMG 7x7 (out 3x3), m_ready=1, 9 back-to-back words 1..9 -> m_data 1..9 each appear one cycle after their write. m_last_col=1 on 3, 6, 9; m_last_frame=1 on 9 only. frame_done pulses once after 9 drains; overflow=0.
- IMG 7x7, FIFO_DEPTH=4, m_ready=0, 6 words -> fill_level=4, overflow=1, and counters sit at col=1, row=1. After m_ready=1 the outputs are words 1..4 in order.
- Full FIFO with Valid_In and m_ready=1 in the same cycle -> the word is accepted, fill_level stays 4, overflow unchanged.
- After the 9th word, 2 extra Valid_In words while draining -> both are dropped, overflow=1. Asserting clear for one cycle gives overflow=0 and the IDLE state.
- rst=0 asserted mid-frame after 5 words -> m_valid=0 and fill_level=0 immediately. A new frame of 9 words then yields correct tags starting at col=0, row=0.
- COLLECTOR_RELU_EN defined: inputs 0xFFFFFFFF, 0x00000005, 0x80000000 -> outputs 0, 5, 0. Without the macro the same inputs pass through unchanged.
